// File: rtl/bitstream_decoder.sv
// -----------------------------------------------------------------------------
// bitstream_decoder
//
// Reader end of the bitstream network. It turns per-lane stochastic (unipolar)
// bitstreams back into binary values. On a start request it counts the ones on
// every lane over a window of 2^WIDTH clock cycles. It then latches the
// saturated counts to value_out and pulses done for one cycle.
//
// Parameters:
//   LANES  number of independent bitstream lanes decoded in parallel
//   WIDTH  result width per lane; the window length is 2^WIDTH cycles
//
// Ports:
//   clk        system clock, all state on the rising edge
//   n_rst      asynchronous active-low reset (clears FSM, counters and results)
//   start      begin one decode window; only honoured while idle
//   bit_in     one bitstream bit per lane per cycle, lane i on bit i
//   busy       high while a window is being counted
//   done       one-cycle pulse when value_out has been updated
//   value_out  decoded results, lane i at [i*WIDTH +: WIDTH]
//
// Build option:
//   BITSTREAM_DECODER_BIPOLAR_EN  when defined, each lane result is the
//   two's-complement bipolar value count - 2^(WIDTH-1), clamped to
//   [-2^(WIDTH-1), 2^(WIDTH-1)-1]. When undefined, each lane result is the
//   unipolar value min(count, 2^WIDTH-1). Ports, timing and FSM are the same
//   in both builds.
// -----------------------------------------------------------------------------
module bitstream_decoder #(
  parameter int LANES = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [LANES-1:0]         bit_in,
  output logic                     busy,
  output logic                     done,
  output logic [LANES*WIDTH-1:0]   value_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                      state;
  logic [WIDTH-1:0]            win_cnt;
  // One extra bit so an all-ones window reaches 2^WIDTH instead of wrapping.
  logic [LANES-1:0][WIDTH:0]   lane_cnt;
  logic [LANES-1:0][WIDTH:0]   lane_cnt_nxt;
  logic [LANES*WIDTH-1:0]      result_nxt;

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
  localparam logic signed [WIDTH+1:0] BIP_OFFSET = (WIDTH+2)'(2**(WIDTH-1));
  localparam logic signed [WIDTH+1:0] BIP_MAX    = BIP_OFFSET - (WIDTH+2)'(1);
  localparam logic signed [WIDTH+1:0] BIP_MIN    = -BIP_OFFSET;

  // Bipolar: count minus half the window, clamped to the signed WIDTH range.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH:0] cnt);
    logic signed [WIDTH+1:0] diff;
    diff = $signed({1'b0, cnt}) - BIP_OFFSET;
    if (diff > BIP_MAX)
      return BIP_MAX[WIDTH-1:0];
    else if (diff < BIP_MIN)
      return BIP_MIN[WIDTH-1:0];
    else
      return diff[WIDTH-1:0];
  endfunction
`else
  // Unipolar: a full window (2^WIDTH) clamps to all-ones.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH:0] cnt);
    if (cnt[WIDTH])
      return '1;
    else
      return cnt[WIDTH-1:0];
  endfunction
`endif

  // Count including the bit sampled on this edge. The final edge of the
  // window latches this value, so the 2^WIDTH-th bit is part of the result.
  always_comb begin
    lane_cnt_nxt = '0;
    result_nxt   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_cnt_nxt[i] = lane_cnt[i] + {{WIDTH{1'b0}}, bit_in[i]};
      result_nxt[i*WIDTH +: WIDTH] = sat_result(lane_cnt_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      value_out <= '0;
      lane_cnt  <= '0;
      win_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // bit_in is deliberately not sampled on the start edge.
          if (start) begin
            state    <= COUNT;
            busy     <= 1'b1;
            lane_cnt <= '0;
            win_cnt  <= '0;
          end
        end
        COUNT: begin
          lane_cnt <= lane_cnt_nxt;
          win_cnt  <= win_cnt + WIDTH'(1);
          // win_cnt at all-ones means this edge samples the last bit.
          if (win_cnt == '1) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            value_out <= result_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// tb_bitstream_decoder
//
// Directed testbench for bitstream_decoder with LANES=8, WIDTH=8 (256-cycle
// window). Expected lane results are hand-computed constants for both the
// unipolar build and the BITSTREAM_DECODER_BIPOLAR_EN build.
// -----------------------------------------------------------------------------
module tb_bitstream_decoder;

  localparam int LANES = 8;
  localparam int WIDTH = 8;
  localparam int WIN   = 256;

`ifdef BITSTREAM_DECODER_BIPOLAR_EN
  localparam logic [63:0] EXP_ZERO = 64'h8080_8080_8080_8080;
  localparam logic [63:0] EXP_ONES = 64'h7F7F_7F7F_7F7F_7F7F;
  localparam logic [63:0] EXP_PAT2 = 64'h8080_8080_8080_C000;
  localparam logic [63:0] EXP_PAT3 = 64'h0080_7F00_007F_8000;
`else
  localparam logic [63:0] EXP_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] EXP_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_PAT2 = 64'h0000_0000_0000_4080;
  localparam logic [63:0] EXP_PAT3 = 64'h8000_FF80_80FF_0080;
`endif

  logic                   clk;
  logic                   n_rst;
  logic                   start;
  logic [LANES-1:0]       bit_in;
  logic                   busy;
  logic                   done;
  logic [LANES*WIDTH-1:0] value_out;

  int          n_checks;
  int          n_fail;
  logic [63:0] exp_prev;

  bitstream_decoder #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .bit_in    (bit_in),
    .busy      (busy),
    .done      (done),
    .value_out (value_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Per-cycle lane stimulus for sample index j of a window.
  //   0: all zero   1: all ones   2: lane0 every 2nd, lane1 every 4th
  //   3: alternating A5 / 3C across all lanes
  function automatic logic [7:0] pat(input int mode, input int j);
    logic [7:0] v;
    v = 8'h00;
    case (mode)
      1: v = 8'hFF;
      2: begin
        v[0] = (j % 2 == 0);
        v[1] = (j % 4 == 0);
      end
      3: v = (j % 2 == 1) ? 8'hA5 : 8'h3C;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Called at a negedge with the FSM idle (or in the done cycle). Returns at
  // the negedge where done is expected high.
  task automatic do_window(input string tag, input int mode, input bit extra,
                           input logic [63:0] exp_v);
    int busy_n;
    int done_n;
    bit held;
    busy_n = 0;
    done_n = 0;
    held   = 1'b1;
    start  = 1'b1;
    bit_in = 8'hFF;  // must not be counted on the start edge
    for (int j = 0; j < WIN; j++) begin
      @(negedge clk);
      start  = extra && (j == 10 || j == 200);
      bit_in = pat(mode, j);
      if (busy) busy_n++;
      if (done) done_n++;
      if (value_out !== exp_prev) held = 1'b0;
    end
    @(negedge clk);
    start  = 1'b0;
    bit_in = 8'h00;
    check({tag, "_done"},   {63'd0, done}, 64'd1);
    check({tag, "_busy"},   {63'd0, busy}, 64'd0);
    check({tag, "_value"},  value_out, exp_v);
    check({tag, "_busyn"},  64'(busy_n), 64'(WIN));
    check({tag, "_doneq"},  64'(done_n), 64'd0);
    check({tag, "_held"},   {63'd0, held}, 64'd1);
    exp_prev = exp_v;
  endtask

  initial begin
    int d_n;
    bit held;
    n_checks = 0;
    n_fail   = 0;
    exp_prev = '0;
    n_rst    = 1'b0;
    start    = 1'b0;
    bit_in   = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_value", value_out, 64'd0);
    n_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);

    do_window("w_zero", 0, 1'b0, EXP_ZERO);
    @(negedge clk);
    check("w_zero_pulse", {63'd0, done}, 64'd0);

    do_window("w_ones", 1, 1'b0, EXP_ONES);
    @(negedge clk);
    check("w_ones_pulse", {63'd0, done}, 64'd0);

    do_window("w_pat2", 2, 1'b0, EXP_PAT2);
    @(negedge clk);

    // extra starts mid-window are ignored; then restart in the done cycle
    do_window("w_extra", 1, 1'b1, EXP_ONES);
    do_window("w_b2b", 2, 1'b0, EXP_PAT2);
    @(negedge clk);
    check("w_b2b_pulse", {63'd0, done}, 64'd0);

    // asynchronous reset in the middle of an all-ones window
    start  = 1'b1;
    bit_in = 8'hFF;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy", {63'd0, busy}, 64'd1);
    n_rst = 1'b0;
    #1;
    check("arst_busy",  {63'd0, busy}, 64'd0);
    check("arst_done",  {63'd0, done}, 64'd0);
    check("arst_value", value_out, 64'd0);
    exp_prev = '0;
    @(negedge clk);
    n_rst = 1'b1;
    d_n = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (done || busy) d_n++;
    end
    check("arst_nodone", 64'(d_n), 64'd0);
    bit_in = 8'h00;

    do_window("w_fresh", 1, 1'b0, EXP_ONES);
    @(negedge clk);

    // toggling bit_in while idle must not disturb value_out
    held = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bit_in = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (value_out !== EXP_ONES) held = 1'b0;
    end
    check("idle_held", {63'd0, held}, 64'd1);

    do_window("w_pat3", 3, 1'b0, EXP_PAT3);
    @(negedge clk);
    check("w_pat3_pulse", {63'd0, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
Name: bitstream_decoder

Overview:
- Reader end of the bitstream network: converts per-lane stochastic (unipolar) bitstreams back into binary values.
- Counts ones on each lane over a fixed window of 2^WIDTH clock cycles.
- Latches the counts to the outputs and raises a one-cycle done pulse.
- Sits downstream of network_control / bitstream lanes; a host or bench drives start and reads value_out.

Parameters:
- LANES, 8, number of independent bitstream lanes decoded in parallel.
- WIDTH, 8, result width per lane; the window length is 2^WIDTH cycles.

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- start  input  1  begin one decode window; only honoured in IDLE.
- bit_in  input  LANES  one bitstream bit per lane per cycle; lane i is bit i.
- busy  output  1  high while a window is being counted.
- done  output  1  one-cycle pulse when value_out has been updated.
- value_out  output  LANES*WIDTH  decoded results; lane i at [i*WIDTH +: WIDTH].

Behaviour:
- Reset is asynchronous and active-low (n_rst=0). It forces state=IDLE, busy=0, done=0, value_out=0, all lane counters=0, and the window counter=0. It takes effect immediately, mid-window included. The partial count is discarded and value_out is cleared.
- FSM has two states.
  - IDLE -> COUNT on a rising edge with start=1. On that edge: lane counters and window counter clear, busy goes to 1. bit_in is not sampled on the start edge.
  - COUNT: on each rising edge, each lane counter increments if bit_in[i]=1, and the window counter increments.
  - COUNT -> IDLE on the edge that samples the 2^WIDTH-th bit. On that edge value_out is loaded and done=1 for exactly one cycle. busy returns to 0 on the same edge.
- Latency: start sampled at edge k, bits sampled at edges k+1 .. k+2^WIDTH, done and value_out valid after edge k+2^WIDTH.
- Lane counters are WIDTH+1 bits (range 0 .. 2^WIDTH).
- Unipolar output is min(count, 2^WIDTH-1): an all-ones window saturates to all-ones, it does not wrap to 0.
- start=1 while in COUNT is ignored and does not restart the window.
- start=1 in the cycle done is high is accepted, since the FSM is already in IDLE. Back-to-back windows therefore have no dead cycle beyond the start edge.
- value_out holds its last result until the next window completes. It does not change during COUNT.
- done is never high while busy is high.

Optional Feature:
- Macro: BITSTREAM_DECODER_BIPOLAR_EN.
- Defined: value_out lanes are two's-complement signed bipolar results, equal to count - 2^(WIDTH-1), clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - WIDTH=8: all zeros -> -128 (0x80), half ones -> 0, all ones -> +127 (0x7F) saturated.
- Undefined: unipolar saturating result as above. Ports, timing and FSM are identical in both builds.

Test Plan (defaults LANES=8, WIDTH=8; window 256 cycles):
- Reset then start pulse, bit_in=8'h00 for 256 cycles -> done pulses once at edge start+256, every lane 0x00, busy high for exactly 256 cycles.
- bit_in=8'hFF held for the window -> every lane 0xFF (saturated), not 0x00; in bipolar build every lane 0x7F.
- Lane 0 alternating 1/0, lane 1 one high bit every 4 cycles, other lanes 0 -> lane0=128 (0x80), lane1=64 (0x40), others 0; in bipolar build lane0=0x00, lane1=0xC0 (-64).
- Extra start pulses at cycles 10 and 200 of a window -> ignored, done still at start+256 and results unchanged. Then start asserted in the done cycle -> new window begins, next done at +256.
- n_rst pulsed low at cycle 100 of an all-ones window -> busy, done, value_out go to 0 immediately with no done pulse. A fresh start then yields 0xFF after 256 cycles.
- After a completed window, bit_in toggled while IDLE and during the next COUNT -> value_out holds its previous value until the next done.
